// File: rtl/guess_pkg.sv
// guess_pkg: shared types and constants for the guess display slice.
//   state_t     - display FSM states
//   SEG_*       - fixed segment patterns {g,f,e,d,c,b,a}, active-high
//   RESULT_WIN  - per-bit match vector that counts as a full match
package guess_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HITS    = 2'd1,
    WIN_ON  = 2'd2,
    WIN_OFF = 2'd3
  } state_t;

  localparam logic [6:0] SEG_DASH   = 7'h40;
  localparam logic [6:0] SEG_ALL    = 7'h7F;
  localparam logic [6:0] SEG_OFF    = 7'h00;
  localparam logic [5:0] RESULT_WIN = 6'h3F;

endpackage

// File: rtl/guess_display_if.sv
// guess_display_if: result strobe from the game core plus the display outputs.
//   master - game core / board side: drives result, result_valid; observes outputs
//   slave  - guess_display: consumes result, drives seg, dp, busy, wins
interface guess_display_if;
  logic [5:0] result;
  logic       result_valid;
  logic [6:0] seg;
  logic       dp;
  logic       busy;
  logic [3:0] wins;

  modport master (output result, result_valid, input seg, dp, busy, wins);
  modport slave  (input result, result_valid, output seg, dp, busy, wins);
endinterface

// File: rtl/seg7_hits.sv
// seg7_hits: popcount of a 6-bit match vector, encoded as a seven-segment digit.
//   result - per-bit match vector
//   seg    - segments {g,f,e,d,c,b,a} for the hit count 0-5; a count of 6 is
//            a win and never displayed as a digit, so it maps to all-on
module seg7_hits
  import guess_pkg::*;
(
  input  logic [5:0] result,
  output logic [6:0] seg
);

  logic [2:0] hits;

  always_comb begin
    hits = 3'd0;
    for (int i = 0; i < 6; i++) hits = hits + {2'b00, result[i]};
  end

  always_comb begin
    case (hits)
      3'd0:    seg = 7'h3F;
      3'd1:    seg = 7'h06;
      3'd2:    seg = 7'h5B;
      3'd3:    seg = 7'h4F;
      3'd4:    seg = 7'h66;
      3'd5:    seg = 7'h6D;
      default: seg = SEG_ALL;
    endcase
  end

endmodule

// File: rtl/guess_display.sv
// guess_display: latches each game result and drives one seven-segment digit.
// Partial matches show the hit count for HOLD_CYC cycles; a full match plays a
// flashing animation (WIN_FLASHES on/off pairs of FLASH_DIV cycles each) and
// bumps a saturating 4-bit win counter.
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - guess_display_if.slave: result/result_valid in; seg, dp, busy, wins out
module guess_display
  import guess_pkg::*;
#(
  parameter int HOLD_CYC    = 8,
  parameter int FLASH_DIV   = 4,
  parameter int WIN_FLASHES = 3
) (
  input  logic           clk,
  input  logic           rst,
  guess_display_if.slave bus
);

  localparam int TMAX = (HOLD_CYC > FLASH_DIV) ? HOLD_CYC : FLASH_DIV;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FCW  = $clog2(WIN_FLASHES + 1);

  localparam logic [TW-1:0]  HOLD_LD  = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0]  FLASH_LD = TW'(FLASH_DIV - 1);
  localparam logic [FCW-1:0] FC_LAST  = FCW'(WIN_FLASHES);

  state_t         state;
  logic [TW-1:0]  timer;
  logic [FCW-1:0] fcnt;
  logic [FCW-1:0] fcnt_nx;
  logic [6:0]     hit_seg;
  logic [6:0]     seg_q;
  logic           dp_q, busy_q;
  logic [3:0]     wins_q;

  seg7_hits u_hits (.result(bus.result), .seg(hit_seg));

  assign fcnt_nx  = fcnt + FCW'(1);
  assign bus.seg  = seg_q;
  assign bus.dp   = dp_q;
  assign bus.busy = busy_q;
  assign bus.wins = wins_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      timer  <= '0;
      fcnt   <= '0;
      seg_q  <= SEG_DASH;
      dp_q   <= 1'b0;
      busy_q <= 1'b0;
      wins_q <= 4'd0;
    end else begin
      case (state)
        IDLE, HITS: begin
          if (bus.result_valid) begin
            if (bus.result == RESULT_WIN) begin
              state  <= WIN_ON;
              timer  <= FLASH_LD;
              fcnt   <= '0;
              seg_q  <= SEG_ALL;
              dp_q   <= 1'b1;
              busy_q <= 1'b1;
              if (wins_q != 4'hF) wins_q <= wins_q + 4'd1;
            end else begin
              // a new result while holding simply restarts the hold
              state <= HITS;
              timer <= HOLD_LD;
              seg_q <= hit_seg;
              dp_q  <= 1'b0;
            end
          end else if (state == HITS) begin
            if (timer == '0) begin
              state <= IDLE;
              seg_q <= SEG_DASH;
            end else begin
              timer <= timer - TW'(1);
            end
          end
        end
        // strobes during the animation are deliberately dropped
        WIN_ON: begin
          if (timer == '0) begin
            state <= WIN_OFF;
            timer <= FLASH_LD;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        WIN_OFF: begin
          if (timer == '0) begin
            fcnt <= fcnt_nx;
            if (fcnt_nx == FC_LAST) begin
              state  <= IDLE;
              seg_q  <= SEG_DASH;
              busy_q <= 1'b0;
            end else begin
              state <= WIN_ON;
              timer <= FLASH_LD;
              seg_q <= SEG_ALL;
              dp_q  <= 1'b1;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          seg_q  <= SEG_DASH;
          dp_q   <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_guess_display.sv
module tb_guess_display;

  localparam int HOLD_CYC    = 8;
  localparam int FLASH_DIV   = 4;
  localparam int WIN_FLASHES = 3;
  localparam int WIN_LEN     = 2 * FLASH_DIV * WIN_FLASHES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  guess_display_if gif();

  guess_display #(
    .HOLD_CYC(HOLD_CYC), .FLASH_DIV(FLASH_DIV), .WIN_FLASHES(WIN_FLASHES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(gif.slave)
  );

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic       busy;
    logic [3:0] wins;
  } exp_t;

  typedef struct {
    logic [5:0] res;
    logic [6:0] seg;
  } vec_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   wins_m = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      nvec++; nerr++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, ".seg"},  32'(gif.seg),  32'(e.seg));
    chk({nm, ".dp"},   32'(gif.dp),   32'(e.dp));
    chk({nm, ".busy"}, 32'(gif.busy), 32'(e.busy));
    chk({nm, ".wins"}, 32'(gif.wins), 32'(e.wins));
  endtask

  // one-cycle strobe; expected outputs after the sampling edge go on the queue
  task automatic strobe(input logic [5:0] res, input exp_t e, input string nm);
    gif.result       = res;
    gif.result_valid = 1'b1;
    exp_q.push_back(e);
    tick();
    gif.result_valid = 1'b0;
    pop_chk(nm);
  endtask

  function automatic exp_t mk(logic [6:0] s, logic d, logic b, logic [3:0] w);
    exp_t e;
    e.seg = s; e.dp = d; e.busy = b; e.wins = w;
    return e;
  endfunction

  task automatic win(input string nm);
    wins_m = (wins_m < 15) ? wins_m + 1 : 15;
    strobe(6'h3F, mk(7'h7F, 1'b1, 1'b1, 4'(wins_m)), nm);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{6'b101101, 7'h66};
    vecs[1] = '{6'b000001, 7'h06};
    vecs[2] = '{6'b000011, 7'h5B};
    vecs[3] = '{6'b000111, 7'h4F};
    vecs[4] = '{6'b001111, 7'h66};
    vecs[5] = '{6'b011111, 7'h6D};
    vecs[6] = '{6'b000000, 7'h3F};
    vecs[7] = '{6'b100000, 7'h06};
    vecs[8] = '{6'b110110, 7'h66};
    vecs[9] = '{6'b101010, 7'h4F};

    gif.result = 6'h00;
    gif.result_valid = 1'b0;

    // reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_q.push_back(mk(7'h40, 1'b0, 1'b0, 4'd0));
    pop_chk("reset");

    // result without strobe is ignored
    gif.result = 6'h3F;
    tick();
    exp_q.push_back(mk(7'h40, 1'b0, 1'b0, 4'd0));
    pop_chk("no_strobe");

    // table: back-to-back partial matches, each restarting the hold
    for (int i = 0; i < 10; i++)
      strobe(vecs[i].res, mk(vecs[i].seg, 1'b0, 1'b0, 4'd0), $sformatf("vec%0d", i));
    repeat (HOLD_CYC - 1) tick();
    chk("hold_last", 32'(gif.seg), 32'h4F);
    tick();
    chk("hold_end", 32'(gif.seg), 32'h40);

    // partial match hold length
    strobe(6'b101101, mk(7'h66, 1'b0, 1'b0, 4'd0), "hits4");
    repeat (HOLD_CYC - 1) tick();
    chk("hits4_k7", 32'(gif.seg), 32'h66);
    tick();
    chk("hits4_k8", 32'(gif.seg), 32'h40);

    // re-strobe during hold restarts it
    strobe(6'b000001, mk(7'h06, 1'b0, 1'b0, 4'd0), "re1");
    tick(); tick();
    strobe(6'b000111, mk(7'h4F, 1'b0, 1'b0, 4'd0), "re2");
    repeat (HOLD_CYC - 1) tick();
    chk("re_hold", 32'(gif.seg), 32'h4F);
    tick();
    chk("re_end", 32'(gif.seg), 32'h40);

    // win animation with an ignored mid-animation strobe
    win("win1");
    for (int j = 1; j < WIN_LEN; j++) begin
      if (j == 6) begin
        gif.result = 6'h01;
        gif.result_valid = 1'b1;
      end
      tick();
      gif.result_valid = 1'b0;
      chk($sformatf("anim%0d.seg", j), 32'(gif.seg),
          ((j / FLASH_DIV) % 2 == 0) ? 32'h7F : 32'h00);
      chk($sformatf("anim%0d.busy", j), 32'(gif.busy), 32'd1);
    end
    tick();
    exp_q.push_back(mk(7'h40, 1'b0, 1'b0, 4'd1));
    pop_chk("anim_end");
    // strobe right after the animation is accepted
    strobe(6'b000011, mk(7'h5B, 1'b0, 1'b0, 4'd1), "post_win");

    // saturation: 16 wins total, then one more at 15
    for (int n = 0; n < 16; n++) begin
      win($sformatf("sat%0d", n));
      repeat (WIN_LEN) tick();
    end
    chk("sat_wins", 32'(gif.wins), 32'd15);
    chk("sat_idle", 32'(gif.busy), 32'd0);

    // reset mid-animation
    win("win_rst");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wins_m = 0;
    exp_q.push_back(mk(7'h40, 1'b0, 1'b0, 4'd0));
    pop_chk("mid_rst");

    // reset has priority over a same-cycle strobe
    rst = 1'b1;
    gif.result = 6'h3F;
    gif.result_valid = 1'b1;
    tick();
    rst = 1'b0;
    gif.result_valid = 1'b0;
    exp_q.push_back(mk(7'h40, 1'b0, 1'b0, 4'd0));
    pop_chk("rst_prio");

    // zero score
    strobe(6'h00, mk(7'h3F, 1'b0, 1'b0, 4'd0), "zero");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/guess_display.md
# guess_display

Downstream consumer of the guessing game's 6-bit per-bit-match result. Each new result is latched and shown on one active-high seven-segment digit. A partial match shows the count of matching bits (0–5) for a hold period. A full match (6'b111111) plays a flashing win animation and increments a saturating win counter. The block sits between the game core and the board's segment pins.

## Interface
Parameters:
- HOLD_CYC, 8 — cycles a hit count stays displayed; legal range ≥1
- FLASH_DIV, 4 — cycles per half-period of the win flash; legal range ≥1
- WIN_FLASHES, 3 — number of all-on phases in the win animation; legal range ≥1

Ports:
- clk  in  1 — single clock; all state updates on the rising edge
- rst  in  1 — synchronous, active-high reset
- result  in  6 — per-bit match vector from the game core
- result_valid  in  1 — one-cycle strobe; `result` is meaningful only while this is high
- seg  out  7 — segments {g,f,e,d,c,b,a}, active-high, registered
- dp  out  1 — decimal point, active-high, registered
- busy  out  1 — high during the win animation, registered
- wins  out  4 — win count, saturates at 15, registered

## Operation
- States:
  - IDLE: seg = 7'h40 (dash), dp = 0.
  - HITS: shows the hit digit, dp = 0.
  - WIN_ON: seg = 7'h7F, dp = 1.
  - WIN_OFF: seg = 7'h00, dp = 0.
- Hit digit = popcount(result). Possible values are 0–5, because 6 means a full match and takes the win path. Encodings:
  - 0 = 7'h3F
  - 1 = 7'h06
  - 2 = 7'h5B
  - 3 = 7'h4F
  - 4 = 7'h66
  - 5 = 7'h6D
- IDLE or HITS, result_valid = 1:
  - result == 6'h3F → WIN_ON; flash counter = 0; timer = FLASH_DIV−1; wins = min(wins+1, 15).
  - Otherwise → HITS; latch the digit; timer = HOLD_CYC−1. This also applies when already in HITS: a new result restarts the hold.
- HITS, no strobe: when timer == 0 → IDLE; otherwise decrement timer.
- WIN_ON, timer == 0 → WIN_OFF; timer reloads to FLASH_DIV−1.
- WIN_OFF, timer == 0:
  - Increment the flash counter.
  - If it reaches WIN_FLASHES → IDLE.
  - Otherwise → WIN_ON; timer reloads.
- busy = 1 exactly in WIN_ON/WIN_OFF. result_valid while busy is dropped: no latch, no win increment.
- result = 6'h00 with result_valid is a normal score of 0 and displays 7'h3F.
- A result value without result_valid is ignored.

## Timing
- Reset values: state = IDLE, seg = 7'h40, dp = 0, busy = 0, wins = 0, timer = 0, flash counter = 0.
- Reset has priority over result_valid in the same cycle.
- Reset mid-animation returns to IDLE on the next edge. wins is cleared.
- Latency: if result_valid is sampled at edge k, seg/dp/busy/wins show the new value after edge k (one register stage).
- A HITS entry at edge k returns to IDLE at edge k+HOLD_CYC, provided no further strobe arrives.
- Win animation length: 2·FLASH_DIV·WIN_FLASHES cycles from entry to IDLE.
- busy deasserts on the same edge as the transition to IDLE. A strobe in the following cycle is accepted.
- Timer width: $clog2(max(HOLD_CYC, FLASH_DIV)+1).
- Flash counter width: $clog2(WIN_FLASHES+1).
- wins saturation: a win at wins == 15 leaves wins at 15 and still plays the animation.

## Structure
- Shared package guess_pkg holds:
  - the state enum (IDLE, HITS, WIN_ON, WIN_OFF)
  - segment constants SEG_DASH, SEG_ALL, SEG_OFF
  - RESULT_WIN = 6'h3F
- Sub-module seg7_hits: combinational popcount of the 6-bit vector plus digit-to-segment encode (0–5). It is instantiated once. The FSM, timers and output registers live in guess_display.

## Test plan
- Reset then idle: assert rst for 2 cycles → seg = 7'h40, dp = 0, busy = 0, wins = 0.
- Partial match: strobe result = 6'b101101 → next cycle seg = 7'h66 (4 hits). With HOLD_CYC = 8, seg returns to 7'h40 after edge k+8.
- Re-strobe during hold: 6'b000001, then 3 cycles later 6'b000111 → seg goes 7'h06 then 7'h4F; the hold restarts from the second strobe.
- Win animation: strobe 6'h3F with FLASH_DIV = 4, WIN_FLASHES = 3 → wins = 1, busy high for 24 cycles; seg pattern 7'h7F×4, 7'h00×4, repeated 3 times; then 7'h40. A strobe 6'h01 injected mid-animation is ignored.
- Saturation plus reset mid-animation: 16 wins → wins = 15. Then assert rst during WIN_ON → next edge seg = 7'h40, busy = 0, wins = 0.
- Zero score: strobe 6'h00 → seg = 7'h3F, wins unchanged.
